// File: rtl/elevator_request_bank_if.sv
// elevator_request_bank_if
//   Groups the request bank's button, service and request-state signals.
//   master: the controller side (drives buttons/service, reads request state).
//   slave : the request bank itself.
//   Signals:
//     car_btn[2:0]   raw car buttons, bit i = floor i+1
//     hall_up[2:0]   raw hall up buttons (bit 2 has no button)
//     hall_dn[2:0]   raw hall down buttons (bit 0 has no button)
//     cur_floor[1:0] current floor 1..3, 0 = between floors
//     svc_valid      service event at cur_floor this cycle
//     svc_dir[1:0]   00 idle, 01 up, 10 down, 11 same as idle
//     pend_car/pend_up/pend_dn[2:0]  pending requests
//     req_above/req_below/req_here   registered floor summaries
//     lamp[8:0]      {pend_dn, pend_up, pend_car}, registered
//   Handshake: svc_valid is a single-cycle strobe with no ready; a service
//   event is consumed in the cycle it is asserted.
interface elevator_request_bank_if;
    logic [2:0] car_btn;
    logic [2:0] hall_up;
    logic [2:0] hall_dn;
    logic [1:0] cur_floor;
    logic       svc_valid;
    logic [1:0] svc_dir;
    logic [2:0] pend_car;
    logic [2:0] pend_up;
    logic [2:0] pend_dn;
    logic       req_above;
    logic       req_below;
    logic       req_here;
    logic [8:0] lamp;

    modport master (
        output car_btn, hall_up, hall_dn, cur_floor, svc_valid, svc_dir,
        input  pend_car, pend_up, pend_dn, req_above, req_below, req_here, lamp
    );

    modport slave (
        input  car_btn, hall_up, hall_dn, cur_floor, svc_valid, svc_dir,
        output pend_car, pend_up, pend_dn, req_above, req_below, req_here, lamp
    );
endinterface

// File: rtl/elevator_request_bank.sv
// elevator_request_bank
//   Conditions raw elevator push-buttons (2-flop sync, debounce, rising-edge
//   detect) and holds each accepted press as a sticky pending bit until the
//   controller reports that floor/direction served.  Provides registered
//   above/below/here summaries and button lamps to the controller FSM.
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     bus  elevator_request_bank_if.slave (buttons, service, request state)
//   Internally the nine button lanes are packed as {dn[2:0], up[2:0], car[2:0]},
//   the same order as lamp.  Lanes with no physical button (up at floor 3,
//   down at floor 1) are forced to 0 at the input so they can never set.
module elevator_request_bank #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    elevator_request_bank_if.slave        bus
);

    localparam logic [8:0]       LANE_EXISTS = 9'b110_011_111;
    localparam logic [CNT_W-1:0] DB_LIMIT    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [8:0]       raw;
    logic [8:0]       sync1_q, sync2_q;
    logic [8:0]       stable_q, stable_d;
    logic [8:0]       stable_prev_q;
    logic [CNT_W-1:0] cnt_q [9];
    logic [CNT_W-1:0] cnt_d [9];
    logic [8:0]       set_pulse;
    logic [8:0]       clr;
    logic [2:0]       floor_oh;
    logic [8:0]       pend_q, pend_d;
    logic [2:0]       floor_any;
    logic             above_q, above_d;
    logic             below_q, below_d;
    logic             here_q, here_d;
    logic [8:0]       lamp_q, lamp_d;

    assign raw = {bus.hall_dn, bus.hall_up, bus.car_btn} & LANE_EXISTS;

    // Debounce: the counter only runs while the synced level disagrees with
    // the accepted level; any agreement restarts it, so short glitches die.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 9; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] + CNT_ONE == DB_LIMIT) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign set_pulse = stable_q & ~stable_prev_q;

    // Service clears the car call at cur_floor plus the hall call(s) in the
    // served direction; idle (00/11) serves both hall directions.
    always_comb begin
        floor_oh = 3'b000;
        clr      = 9'b0;
        case (bus.cur_floor)
            2'd1:    floor_oh = 3'b001;
            2'd2:    floor_oh = 3'b010;
            2'd3:    floor_oh = 3'b100;
            default: floor_oh = 3'b000;
        endcase
        if (bus.svc_valid) begin
            clr[2:0] = floor_oh;
            if (bus.svc_dir != 2'b10) clr[5:3] = floor_oh;
            if (bus.svc_dir != 2'b01) clr[8:6] = floor_oh;
        end
        clr = clr & LANE_EXISTS;
    end

    // Clear wins over a coincident set: that press counts as served.
    assign pend_d = (pend_q | set_pulse) & ~clr & LANE_EXISTS;

    // Summaries and lamps are one register stage behind the pending bits.
    always_comb begin
        for (int f = 0; f < 3; f++) begin
            floor_any[f] = pend_q[f] | pend_q[3+f] | pend_q[6+f];
        end
        above_d = 1'b0;
        below_d = 1'b0;
        here_d  = 1'b0;
        case (bus.cur_floor)
            2'd1: begin
                above_d = |floor_any[2:1];
                here_d  = floor_any[0];
            end
            2'd2: begin
                above_d = floor_any[2];
                below_d = floor_any[0];
                here_d  = floor_any[1];
            end
            2'd3: begin
                below_d = |floor_any[1:0];
                here_d  = floor_any[2];
            end
            default: begin
                above_d = 1'b0;
                below_d = 1'b0;
                here_d  = 1'b0;
            end
        endcase
        lamp_d = pend_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 9; i++) cnt_q[i] <= '0;
            pend_q        <= '0;
            above_q       <= 1'b0;
            below_q       <= 1'b0;
            here_q        <= 1'b0;
            lamp_q        <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 9; i++) cnt_q[i] <= cnt_d[i];
            pend_q        <= pend_d;
            above_q       <= above_d;
            below_q       <= below_d;
            here_q        <= here_d;
            lamp_q        <= lamp_d;
        end
    end

    assign bus.pend_car  = pend_q[2:0];
    assign bus.pend_up   = pend_q[5:3];
    assign bus.pend_dn   = pend_q[8:6];
    assign bus.req_above = above_q;
    assign bus.req_below = below_q;
    assign bus.req_here  = here_q;
    assign bus.lamp      = lamp_q;

endmodule

// File: tb/tb_elevator_request_bank.sv
// tb_elevator_request_bank
//   Bench for elevator_request_bank with DEBOUNCE_CYCLES = 4.  A behavioural
//   model (raw-sample history per button, pending set, floor summaries) is
//   stepped on every clock edge and compared against the DUT; a table of
//   hand-derived vectors and a few hand-written sequences cover the listed
//   corner cases, followed by a randomized phase.
module tb_elevator_request_bank;
  localparam int D = 4;
  localparam logic [15:0] WIN = (16'(1) << D) - 16'(1);
  localparam logic [8:0] REAL_BTN = 9'b110_011_111;

  logic clk = 1'b0;
  logic rst;
  elevator_request_bank_if bus();

  elevator_request_bank #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // ---------------- reference model ----------------
  logic [15:0] m_hist [9];
  logic [8:0]  m_stable;
  logic [8:0]  m_rose;
  logic [8:0]  m_pend;
  logic [8:0]  m_lamp;
  logic        m_above, m_below, m_here;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_hist[i] = '0;
    m_stable = '0;
    m_rose   = '0;
    m_pend   = '0;
    m_lamp   = '0;
    m_above  = 1'b0;
    m_below  = 1'b0;
    m_here   = 1'b0;
  endtask

  task automatic model_edge();
    logic [8:0] raw;
    logic [8:0] clr;
    logic [2:0] any;
    int k;
    int cf;
    raw = {bus.hall_dn, bus.hall_up, bus.car_btn};
    cf  = int'(bus.cur_floor);
    clr = '0;
    if (bus.svc_valid && cf != 0) begin
      k = cf - 1;
      clr[k] = 1'b1;
      if (bus.svc_dir != 2'b10) clr[3+k] = 1'b1;
      if (bus.svc_dir != 2'b01) clr[6+k] = 1'b1;
    end
    for (int f = 0; f < 3; f++) any[f] = m_pend[f] | m_pend[3+f] | m_pend[6+f];
    m_above = 1'b0;
    m_below = 1'b0;
    m_here  = 1'b0;
    if (cf != 0) begin
      for (int f = 1; f <= 3; f++) begin
        if (any[f-1] && f > cf) m_above = 1'b1;
        if (any[f-1] && f < cf) m_below = 1'b1;
        if (any[f-1] && f == cf) m_here = 1'b1;
      end
    end
    m_lamp = m_pend;
    m_pend = (m_pend | m_rose) & ~clr & REAL_BTN;
    // A level is accepted once the last D synchroniser outputs (raw delayed
    // by two edges) all disagreed with the accepted level.
    for (int i = 0; i < 9; i++) begin
      if (((m_hist[i] >> 1) & WIN) == (m_stable[i] ? 16'h0 : WIN)) begin
        m_stable[i] = ~m_stable[i];
        m_rose[i]   = m_stable[i];
      end else begin
        m_rose[i] = 1'b0;
      end
      m_hist[i] = {m_hist[i][14:0], raw[i]};
    end
  endtask

  function automatic logic [20:0] dut_vec();
    return {bus.lamp, bus.req_above, bus.req_below, bus.req_here,
            bus.pend_dn, bus.pend_up, bus.pend_car};
  endfunction

  function automatic logic [20:0] model_vec();
    return {m_lamp, m_above, m_below, m_here, m_pend};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (lamp,abv,blw,here,dn,up,car)", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] car, input logic [2:0] up, input logic [2:0] dn,
                       input logic [1:0] fl, input logic sv, input logic [1:0] dir);
    bus.car_btn   = car;
    bus.hall_up   = up;
    bus.hall_dn   = dn;
    bus.cur_floor = fl;
    bus.svc_valid = sv;
    bus.svc_dir   = dir;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("async_rst", dut_vec(), 21'h0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] car, up, dn;
    logic [1:0] fl;
    logic       sv;
    logic [1:0] dir;
    int         cyc;
    logic [2:0] e_car, e_up, e_dn;
    logic       e_ab, e_be, e_he;
    logic [8:0] e_lamp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    tbl[0]  = '{3'b100, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0, 12, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 9'b000_000_100};
    tbl[1]  = '{3'b000, 3'b001, 3'b000, 2'd1, 1'b0, 2'd0,  3, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 9'b000_000_100};
    tbl[2]  = '{3'b000, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0,  8, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 9'b000_000_100};
    tbl[3]  = '{3'b000, 3'b010, 3'b010, 2'd1, 1'b0, 2'd0, 12, 3'b100, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 9'b010_010_100};
    tbl[4]  = '{3'b000, 3'b000, 3'b000, 2'd2, 1'b0, 2'd0, 10, 3'b100, 3'b010, 3'b010, 1'b1, 1'b0, 1'b1, 9'b010_010_100};
    tbl[5]  = '{3'b000, 3'b000, 3'b000, 2'd2, 1'b1, 2'd1,  1, 3'b100, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1, 9'b010_010_100};
    tbl[6]  = '{3'b000, 3'b000, 3'b000, 2'd2, 1'b0, 2'd0,  1, 3'b100, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1, 9'b010_000_100};
    tbl[7]  = '{3'b000, 3'b000, 3'b000, 2'd2, 1'b1, 2'd2,  1, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 9'b010_000_100};
    tbl[8]  = '{3'b000, 3'b000, 3'b000, 2'd2, 1'b0, 2'd0,  1, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 9'b000_000_100};
    tbl[9]  = '{3'b000, 3'b000, 3'b000, 2'd3, 1'b1, 2'd0,  1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 9'b000_000_100};
    tbl[10] = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 2'd0,  2, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'b000_000_000};
    tbl[11] = '{3'b000, 3'b100, 3'b001, 2'd1, 1'b0, 2'd0, 12, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'b000_000_000};
    tbl[12] = '{3'b010, 3'b000, 3'b000, 2'd0, 1'b0, 2'd0, 12, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'b000_000_010};
    tbl[13] = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b1, 2'd0,  2, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'b000_000_010};
    tbl[14] = '{3'b000, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0,  2, 3'b010, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 9'b000_000_010};
    tbl[15] = '{3'b000, 3'b000, 3'b000, 2'd2, 1'b1, 2'd3,  1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 9'b000_000_010};
    tbl[16] = '{3'b000, 3'b000, 3'b000, 2'd2, 1'b0, 2'd0,  2, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'b000_000_000};

    // ---- reset ----
    drive(3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_vec(), 21'h0);
    rst = 1'b0;

    // ---- latency: car floor 3 raised before edge 1 ----
    drive(3'b100, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0);
    repeat (6) step();
    check("lat_edge6", {18'h0, bus.pend_car}, 21'h0);
    step();
    check("lat_edge7", {12'h0, bus.lamp, bus.pend_car}, {12'h0, 9'h0, 3'b100});
    step();
    check("lat_edge8", {11'h0, bus.req_above, bus.lamp, bus.pend_car},
          {11'h0, 1'b1, 9'b000_000_100, 3'b100});

    // ---- table-driven vectors ----
    for (int v = 0; v < 17; v++) begin
      drive(tbl[v].car, tbl[v].up, tbl[v].dn, tbl[v].fl, tbl[v].sv, tbl[v].dir);
      repeat (tbl[v].cyc) step();
      check($sformatf("table%0d", v), dut_vec(),
            {tbl[v].e_lamp, tbl[v].e_ab, tbl[v].e_be, tbl[v].e_he,
             tbl[v].e_dn, tbl[v].e_up, tbl[v].e_car});
    end

    // ---- held button: one set, served while held, needs re-press ----
    drive(3'b001, 3'b000, 3'b000, 2'd2, 1'b0, 2'd0);
    repeat (50) step();
    check("hold_set", {18'h0, bus.pend_car}, {18'h0, 3'b001});
    drive(3'b001, 3'b000, 3'b000, 2'd1, 1'b1, 2'd0);
    step();
    drive(3'b001, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0);
    check("hold_served", {18'h0, bus.pend_car}, 21'h0);
    repeat (20) step();
    check("hold_no_reset", {18'h0, bus.pend_car}, 21'h0);
    drive(3'b000, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0);
    repeat (10) step();
    drive(3'b001, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0);
    repeat (10) step();
    check("hold_repress", {18'h0, bus.pend_car}, {18'h0, 3'b001});
    drive(3'b000, 3'b000, 3'b000, 2'd1, 1'b1, 2'd0);
    step();
    drive(3'b000, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0);
    repeat (10) step();

    // ---- set of car 2 coincides with service at floor 2; car 3 sets too ----
    drive(3'b110, 3'b000, 3'b000, 2'd2, 1'b0, 2'd0);
    for (int i = 0; i < 20 && !m_rose[1]; i++) step();
    n_vec++;
    if (!m_rose[1]) begin
      n_miss++;
      $display("FAIL coincide_wait: got no set pulse expected one within 20 cycles");
    end
    drive(3'b110, 3'b000, 3'b000, 2'd2, 1'b1, 2'd0);
    step();
    drive(3'b000, 3'b000, 3'b000, 2'd2, 1'b0, 2'd0);
    check("coincide", {18'h0, bus.pend_car}, {18'h0, 3'b100});
    repeat (8) step();
    drive(3'b000, 3'b000, 3'b000, 2'd3, 1'b1, 2'd0);
    step();
    drive(3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 2'd0);

    // ---- async reset with requests pending and counters mid-count ----
    drive(3'b011, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0);
    repeat (12) step();
    check("pre_rst", {18'h0, bus.pend_car}, {18'h0, 3'b011});
    drive(3'b011, 3'b101, 3'b011, 2'd1, 1'b0, 2'd0);
    repeat (3) step();
    async_reset();
    repeat (12) step();
    check("post_rst", {12'h0, bus.pend_dn, bus.pend_up, bus.pend_car},
          {12'h0, 3'b010, 3'b001, 3'b011});
    drive(3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 2'd0);
    repeat (8) step();

    // ---- randomized phase ----
    for (int seg = 0; seg < 300; seg++) begin
      drive(3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)));
      for (int c = int'($urandom_range(1, 8)); c > 0; c--) begin
        step();
        bus.svc_valid = ($urandom_range(0, 5) == 0);
        bus.svc_dir   = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 60) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
